// File: rtl/ee354_gcd_param.sv
// ee354_gcd_param -- binary (Stein) GCD engine with an optional LCM stage.
//
// The engine uses a Start/Ack handshake. SCEN single-steps every compute state.
// It handles zero operands, counts the factors of two it removes (i_count) and
// reports the number of compute cycles it took (Steps, saturating).
//
// Build option:
//   EE354_GCD_LCM_EN  defined   -> after the GCD, Q = Ain / gcd (restoring divide,
//                                  WIDTH steps), then AB_LCM = Q * Bin (shift-add,
//                                  WIDTH steps).
//                     undefined -> no LCM hardware; AB_LCM and q_Lcm are tied to 0.
//
// Parameters: WIDTH (operand width, >= 2), CNT_W (Steps counter width)
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   SCEN                single-clock enable for the SUB/MULT/LCM states
//   Start, Ack          handshake (Start is sampled in INIT, Ack in DONE)
//   Ain, Bin            operands; loaded on every INIT cycle
//   A, B                working registers
//   AB_GCD, AB_LCM      results, valid in DONE
//   i_count             common factors of two that were removed
//   Steps               compute cycles taken while SCEN was high
//   q_I .. q_Done       one-hot state flags
module ee354_gcd_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   SCEN,
   input  logic                   Start,
   input  logic                   Ack,
   input  logic [WIDTH-1:0]       Ain,
   input  logic [WIDTH-1:0]       Bin,
   output logic [WIDTH-1:0]       A,
   output logic [WIDTH-1:0]       B,
   output logic [WIDTH-1:0]       AB_GCD,
   output logic [$clog2(WIDTH):0] i_count,
   output logic [2*WIDTH-1:0]     AB_LCM,
   output logic [CNT_W-1:0]       Steps,
   output logic                   q_I,
   output logic                   q_Sub,
   output logic                   q_Mult,
   output logic                   q_Lcm,
   output logic                   q_Done
);

   localparam int IW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      INIT = 3'b000,
      SUB  = 3'b001,
      MULT = 3'b010,
      LCM  = 3'b011,
      DONE = 3'b100
   } state_t;

   state_t state;

   // The state the FSM enters once the GCD is complete.
`ifdef EE354_GCD_LCM_EN
   localparam state_t GCD_NEXT = LCM;
`else
   localparam state_t GCD_NEXT = DONE;
`endif

   logic [CNT_W-1:0] steps_inc;

   always_comb begin
      steps_inc = (Steps == '1) ? Steps : Steps + 1'b1;
   end

`ifdef EE354_GCD_LCM_EN
   // Ain_l holds the dividend. It becomes the quotient during the divide.
   // It is then shifted out as the multiplier.
   // Bin_l holds the multiplicand. It shifts left during the multiply.
   logic [WIDTH-1:0]   Ain_l;
   logic [2*WIDTH-1:0] Bin_l;
   logic [WIDTH-1:0]   lcm_rem;
   logic [2*WIDTH-1:0] lcm_acc;
   logic               lcm_ph;
   logic [IW-1:0]      lcm_cnt;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic               lcm_last;

   always_comb begin
      rem_sh   = {lcm_rem, Ain_l[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, AB_GCD});
      lcm_last = (lcm_cnt == IW'(WIDTH - 1));
   end
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= INIT;
         A       <= '0;
         B       <= '0;
         AB_GCD  <= '0;
         i_count <= '0;
         Steps   <= '0;
`ifdef EE354_GCD_LCM_EN
         Ain_l   <= '0;
         Bin_l   <= '0;
         lcm_rem <= '0;
         lcm_acc <= '0;
         lcm_ph  <= 1'b0;
         lcm_cnt <= '0;
`endif
      end else begin
         case (state)
            INIT: begin
               A       <= Ain;
               B       <= Bin;
               i_count <= '0;
               AB_GCD  <= '0;
               Steps   <= '0;
`ifdef EE354_GCD_LCM_EN
               Ain_l   <= Ain;
               Bin_l   <= (2*WIDTH)'(Bin);
               lcm_rem <= '0;
               lcm_acc <= '0;
               lcm_ph  <= 1'b0;
               lcm_cnt <= '0;
`endif
               if (Start) state <= SUB;
            end
            SUB: if (SCEN) begin
               Steps <= steps_inc;
               if (A == '0 || B == '0) begin
                  AB_GCD <= A | B;
                  state  <= DONE;
               end else if (A == B) begin
                  AB_GCD <= A;
                  state  <= (i_count != '0) ? MULT : GCD_NEXT;
               end else if (A < B) begin
                  A <= B;
                  B <= A;
               end else if (A[0] && B[0]) begin
                  A <= A - B;
               end else if (!A[0] && !B[0]) begin
                  A       <= A >> 1;
                  B       <= B >> 1;
                  i_count <= i_count + 1'b1;
               end else if (!A[0]) begin
                  A <= A >> 1;
               end else begin
                  B <= B >> 1;
               end
            end
            MULT: if (SCEN) begin
               Steps   <= steps_inc;
               AB_GCD  <= AB_GCD << 1;
               i_count <= i_count - 1'b1;
               if (i_count == IW'(1)) state <= GCD_NEXT;
            end
`ifdef EE354_GCD_LCM_EN
            LCM: if (SCEN) begin
               Steps   <= steps_inc;
               lcm_cnt <= lcm_cnt + 1'b1;
               if (!lcm_ph) begin
                  if (rem_ge) begin
                     lcm_rem <= WIDTH'(rem_sh - {1'b0, AB_GCD});
                     Ain_l   <= {Ain_l[WIDTH-2:0], 1'b1};
                  end else begin
                     lcm_rem <= rem_sh[WIDTH-1:0];
                     Ain_l   <= {Ain_l[WIDTH-2:0], 1'b0};
                  end
                  if (lcm_last) begin
                     lcm_ph  <= 1'b1;
                     lcm_cnt <= '0;
                  end
               end else begin
                  if (Ain_l[0]) lcm_acc <= lcm_acc + Bin_l;
                  Bin_l <= Bin_l << 1;
                  Ain_l <= Ain_l >> 1;
                  if (lcm_last) state <= DONE;
               end
            end
`endif
            DONE: if (Ack) state <= INIT;
            default: state <= INIT;
         endcase
      end
   end

   assign q_I    = (state == INIT);
   assign q_Sub  = (state == SUB);
   assign q_Mult = (state == MULT);
   assign q_Done = (state == DONE);

`ifdef EE354_GCD_LCM_EN
   assign q_Lcm  = (state == LCM);
   assign AB_LCM = lcm_acc;
`else
   assign q_Lcm  = 1'b0;
   assign AB_LCM = '0;
`endif

endmodule

// File: tb/tb_ee354_gcd_param.sv
// tb_ee354_gcd_param -- directed bench for ee354_gcd_param.
// It exercises an 8-bit instance and a 16-bit instance.
// Expected LCM values depend on EE354_GCD_LCM_EN; the result is 0 when the macro is undefined.
module tb_ee354_gcd_param;

   logic        Clk = 1'b0;
   logic        Reset, SCEN;
   logic        Start8, Ack8, Start16, Ack16;
   logic [7:0]  Ain8, Bin8, A8, B8, G8;
   logic [3:0]  I8;
   logic [15:0] L8;
   logic [7:0]  S8;
   logic        qi8, qs8, qm8, ql8, qd8;
   logic [15:0] Ain16, Bin16, A16, B16, G16;
   logic [4:0]  I16;
   logic [31:0] L16;
   logic [7:0]  S16;
   logic        qi16, qs16, qm16, ql16, qd16;

   int tests = 0;
   int fails = 0;

`ifdef EE354_GCD_LCM_EN
   localparam bit LCM_ON = 1'b1;
`else
   localparam bit LCM_ON = 1'b0;
`endif

   always #5 Clk = ~Clk;

   ee354_gcd_param #(.WIDTH(8), .CNT_W(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .Start(Start8), .Ack(Ack8),
      .Ain(Ain8), .Bin(Bin8), .A(A8), .B(B8), .AB_GCD(G8), .i_count(I8),
      .AB_LCM(L8), .Steps(S8), .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8),
      .q_Lcm(ql8), .q_Done(qd8));

   ee354_gcd_param #(.WIDTH(16), .CNT_W(8)) dut16 (
      .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .Start(Start16), .Ack(Ack16),
      .Ain(Ain16), .Bin(Bin16), .A(A16), .B(B16), .AB_GCD(G16), .i_count(I16),
      .AB_LCM(L16), .Steps(S16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16),
      .q_Lcm(ql16), .q_Done(qd16));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      Ain8 = a; Bin8 = b; Start8 = 1'b1;
      tick();
      Start8 = 1'b0;
   endtask

   task automatic ack8();
      Ack8 = 1'b1;
      tick();
      Ack8 = 1'b0;
   endtask

   task automatic wait_done8(input string tag);
      int n = 0;
      while (!qd8 && n < 300) begin tick(); n++; end
      chk(tag, qd8, 1);
   endtask

   initial begin
      Reset = 1'b1; SCEN = 1'b1;
      Start8 = 0; Ack8 = 0; Start16 = 0; Ack16 = 0;
      Ain8 = 8'd99; Bin8 = 8'd7; Ain16 = '0; Bin16 = '0;
      repeat (2) tick();

      // Reset state
      chk("rst_A", A8, 0);
      chk("rst_q_I", qi8, 1);
      chk("rst_gcd", G8, 0);
      chk("rst_steps", S8, 0);
      chk("rst_lcm", L8, 0);
      Reset = 1'b0;
      tick();
      chk("init_load_A", A8, 99);

      // Test 1: 36,24
      start8(8'd36, 8'd24);
      wait_done8("t1_done");
      chk("t1_gcd", G8, 12);
      chk("t1_icount", I8, 0);
      chk("t1_lcm", L8, LCM_ON ? 72 : 0);
      chk("t1_steps", S8, LCM_ON ? 24 : 8);
      ack8();
      chk("t1_back_init", qi8, 1);

      // Test 2: zero operands
      start8(8'd0, 8'd45);
      tick();
      chk("t2_done_1step", qd8, 1);
      chk("t2_gcd", G8, 45);
      chk("t2_lcm", L8, 0);
      chk("t2_steps", S8, 1);
      ack8();
      start8(8'd0, 8'd0);
      wait_done8("t2b_done");
      chk("t2b_gcd", G8, 0);
      ack8();

      // Test 3: equal operands, then coprime operands
      start8(8'd17, 8'd17);
      tick();
      chk("t3_gcd_first", G8, 17);
      chk("t3_no_mult", qm8, 0);
      wait_done8("t3_done");
      chk("t3_lcm", L8, LCM_ON ? 17 : 0);
      ack8();
      start8(8'd255, 8'd254);
      wait_done8("t3b_done");
      chk("t3b_gcd", G8, 1);
      chk("t3b_lcm", L8, LCM_ON ? 64770 : 0);
      ack8();

      // Test 4: SCEN freeze inside SUB
      SCEN = 1'b0;
      start8(8'd36, 8'd24);
      repeat (10) tick();
      chk("t4_A_frozen", A8, 36);
      chk("t4_B_frozen", B8, 24);
      chk("t4_state_frozen", qs8, 1);
      chk("t4_steps_frozen", S8, 0);
      SCEN = 1'b1;
      tick();
      chk("t4_A_step", A8, 18);
      chk("t4_B_step", B8, 12);
      chk("t4_icount_step", I8, 1);
      chk("t4_steps_step", S8, 1);
      wait_done8("t4_done");
      chk("t4_gcd", G8, 12);
      chk("t4_lcm", L8, LCM_ON ? 72 : 0);
      ack8();

      // Test 5: reset during MULT
      start8(8'd64, 8'd96);
      begin
         int n = 0;
         while (!qm8 && n < 100) begin tick(); n++; end
      end
      chk("t5_reached_mult", qm8, 1);
      Reset = 1'b1;
      #1;
      chk("t5_rst_q_I", qi8, 1);
      chk("t5_rst_A", A8, 0);
      chk("t5_rst_gcd", G8, 0);
      chk("t5_rst_icount", I8, 0);
      chk("t5_rst_steps", S8, 0);
      tick();
      chk("t5_rst_hold", qi8, 1);
      Reset = 1'b0;
      start8(8'd64, 8'd96);
      wait_done8("t5_done");
      chk("t5_gcd", G8, 32);
      chk("t5_icount", I8, 0);
      chk("t5_lcm", L8, LCM_ON ? 192 : 0);
      ack8();

      // Test 6: 16-bit instance, Ack held for 3 cycles
      Ain16 = 16'd40000; Bin16 = 16'd30000; Start16 = 1'b1;
      tick();
      Start16 = 1'b0;
      begin
         int n = 0;
         while (!qd16 && n < 500) begin tick(); n++; end
      end
      chk("t6_done", qd16, 1);
      chk("t6_gcd", G16, 10000);
      chk("t6_lcm", L16, LCM_ON ? 120000 : 0);
      Ack16 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_ack_q_I", qi16, 1);
         chk("t6_ack_q_Done", qd16, 0);
      end
      Ack16 = 1'b0;
      chk("t6_init_A", A16, 40000);
      chk("t6_init_gcd", G16, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
